// File: rtl/dcdc_mpc_pkg.sv
// Shared types and default widths for the boost-converter finite-set MPC stage.
package dcdc_mpc_pkg;
  localparam int DW          = 32;
  localparam int PW          = 34;
  localparam int K_SHIFT_DEF = 4;

  typedef enum logic [1:0] {IDLE, PRED, COST, DECIDE} state_t;
endpackage

// File: rtl/mpc_predict.sv
// Next-step inductor current prediction for switch ON / OFF (pure combinational).
module mpc_predict #(
  parameter int DW      = 32,
  parameter int PW      = 34,
  parameter int K_SHIFT = 4
) (
  input  logic [DW-1:0]        vpv,
  input  logic [DW-1:0]        ipv,
  input  logic [DW-1:0]        vout,
  output logic signed [PW-1:0] i_on,
  output logic signed [PW-1:0] i_off
);
  logic [PW-1:0] ipv_x, vpv_s, vout_s;

  // Zero-extend before arithmetic so I_off can go negative without wrapping.
  assign ipv_x  = PW'(ipv);
  assign vpv_s  = PW'(vpv >> K_SHIFT);
  assign vout_s = PW'(vout >> K_SHIFT);
  assign i_on   = $signed(ipv_x + vpv_s);
  assign i_off  = $signed(ipv_x + vpv_s - vout_s);
endmodule

// File: rtl/mpc_switch_decider.sv
// Captures samples on a tick, predicts ON/OFF currents, and registers the lower-cost gate state.
module mpc_switch_decider
  import dcdc_mpc_pkg::*;
#(
  parameter int DW      = dcdc_mpc_pkg::DW,
  parameter int K_SHIFT = dcdc_mpc_pkg::K_SHIFT_DEF,
  parameter int PW      = dcdc_mpc_pkg::PW
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_tick,
  input  logic [DW-1:0] i_Vpv,
  input  logic [DW-1:0] i_Ipv,
  input  logic [DW-1:0] i_Vout,
  input  logic [DW-1:0] i_Iref,
  output logic          o_switch,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_overrun
);
  state_t state, state_nx;

  logic [DW-1:0]        vpv_q, ipv_q, vout_q, iref_q;
  logic signed [PW-1:0] i_on_c, i_off_c, i_on_q, i_off_q;
  logic signed [PW-1:0] d_on, d_off;
  logic [PW-1:0]        c_on_q, c_off_q;
  logic                 switch_q, valid_q, overrun_q;

  mpc_predict #(.DW(DW), .PW(PW), .K_SHIFT(K_SHIFT)) u_predict (
    .vpv  (vpv_q),
    .ipv  (ipv_q),
    .vout (vout_q),
    .i_on (i_on_c),
    .i_off(i_off_c)
  );

  assign d_on  = $signed(PW'(iref_q)) - i_on_q;
  assign d_off = $signed(PW'(iref_q)) - i_off_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_tick) state_nx = PRED;
      PRED:    state_nx = COST;
      COST:    state_nx = DECIDE;
      DECIDE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != IDLE);
    o_switch  = switch_q;
    o_valid   = valid_q;
    o_overrun = overrun_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vpv_q     <= '0;
      ipv_q     <= '0;
      vout_q    <= '0;
      iref_q    <= '0;
      i_on_q    <= '0;
      i_off_q   <= '0;
      c_on_q    <= '0;
      c_off_q   <= '0;
      switch_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= (state == DECIDE);
      // Ticks outside IDLE are dropped; only the sticky flag records them.
      if (i_tick && state != IDLE) overrun_q <= 1'b1;
      case (state)
        IDLE: if (i_tick) begin
          vpv_q  <= i_Vpv;
          ipv_q  <= i_Ipv;
          vout_q <= i_Vout;
          iref_q <= i_Iref;
        end
        PRED: begin
          i_on_q  <= i_on_c;
          i_off_q <= i_off_c;
        end
        COST: begin
          c_on_q  <= d_on[PW-1]  ? PW'(-d_on)  : PW'(d_on);
          c_off_q <= d_off[PW-1] ? PW'(-d_off) : PW'(d_off);
        end
        DECIDE: begin
          // Equal costs keep the current gate state to avoid needless switching.
          if (c_on_q < c_off_q)      switch_q <= 1'b1;
          else if (c_off_q < c_on_q) switch_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mpc_switch_decider.md
Name: mpc_switch_decider

Overview:
Finite-set MPC decision stage for the boost converter, directly downstream of the 4096-cycle sampling-tick generator. On each sampling tick it captures Vpv, Ipv and Vout plus the current reference, and predicts the next-step inductor current for switch ON and switch OFF. It then picks the switch state with the lower current-tracking cost and drives the registered gate command.

Parameters:
DW, 32, input data width (unsigned, integer LSB units)
K_SHIFT, 4, right-shift implementing Ts/L scaling of voltage into current delta
PW, 34, internal signed width for predictions and costs (DW+2)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_tick  input  1  one-cycle sampling strobe from upstream tick generator
i_Vpv  input  DW  PV voltage sample, unsigned
i_Ipv  input  DW  PV/inductor current sample, unsigned
i_Vout  input  DW  output voltage sample, unsigned
i_Iref  input  DW  current reference (from MPPT), unsigned
o_switch  output  1  registered gate command, 1 = switch ON
o_valid  output  1  one-cycle pulse: o_switch just updated
o_busy  output  1  high while a decision is in progress
o_overrun  output  1  sticky: tick arrived while busy

Behaviour:
- Clock: i_clk only. Reset: asynchronous, active-low (i_reset_n); all flops clear immediately on assertion.
- Reset values: o_switch=0, o_valid=0, o_busy=0, o_overrun=0, FSM=IDLE, all capture/prediction/cost registers=0.
- FSM states: IDLE, PRED, COST, DECIDE.
- IDLE:
  - If i_tick=1 at an edge, latch Vpv, Ipv, Vout, Iref.
  - Set o_busy=1 and go to PRED. Otherwise stay.
- PRED (one cycle). Register signed PW-bit values:
  - I_on = Ipv + (Vpv>>K_SHIFT)
  - I_off = Ipv + (Vpv>>K_SHIFT) - (Vout>>K_SHIFT)
  - All operands are zero-extended before the arithmetic. I_off may be negative; no clamping.
- COST (one cycle). Register unsigned:
  - C_on = |Iref - I_on|
  - C_off = |Iref - I_off|
  - Computed at PW bits, so no overflow.
- DECIDE (one cycle):
  - C_on < C_off -> o_switch<=1.
  - C_off < C_on -> o_switch<=0.
  - Tie -> o_switch holds its previous value.
  - o_valid<=1 for exactly this one update; o_busy<=0; go to IDLE.
- Latency: capture edge T0; o_switch and o_valid change at edge T0+3; o_valid clears at T0+4.
- o_busy is high from T0 through T0+3 (inclusive of cycles after T0, T0+1, T0+2), and low from T0+3 on.
- Back-to-back: a tick at T0+3 (FSM in DECIDE) is not accepted. A new tick is accepted only in IDLE, i.e. earliest T0+4.
- Overrun: i_tick=1 in PRED, COST or DECIDE sets o_overrun=1 (sticky until reset). The tick is dropped, and the in-flight decision completes unaffected.
- Inputs are sampled only at the capture edge. Changes during PRED/COST/DECIDE have no effect.
- Reset mid-operation: the FSM returns to IDLE and all outputs go to reset values at once. Nothing is emitted after reset is released until the next tick.
- o_switch is a flop output only; no combinational path from any input.

Decomposition:
- Package dcdc_mpc_pkg:
  - FSM state enum (IDLE, PRED, COST, DECIDE)
  - localparams DW=32 and PW=34
  - default K_SHIFT
- Sub-module mpc_predict (combinational): takes the latched Vpv/Ipv/Vout and K_SHIFT, returns I_on/I_off. Registered by the parent in PRED.
- Cost/compare logic stays in the parent.

Test Plan:
- Reset then tick with K_SHIFT=4, Vpv=160, Ipv=100, Vout=320, Iref=105 -> I_on=110, I_off=90, C_on=5, C_off=15; o_switch=1 and o_valid pulses one cycle, both at T0+3.
- Same samples, Iref=92 -> C_on=18, C_off=2; o_switch=0.
- Tie case: o_switch=1 from the first test, then Iref=100 -> C_on=C_off=10; o_switch stays 1 and o_valid still pulses.
- Negative prediction: Vpv=16, Ipv=0, Vout=480, Iref=0 -> I_off=-29, C_off=29, C_on=1; o_switch=1.
- Overrun: tick at T0 and again at T0+2 -> o_overrun=1 and stays 1; exactly one o_valid pulse. A tick at T0+4 is accepted normally.
- Reset mid-operation: assert i_reset_n=0 during COST -> o_busy, o_switch and o_valid go to 0 immediately. No o_valid after release until the next tick.
